// File: rtl/vram_pkg.sv
// vram_pkg: shared widths, text-screen geometry and the types exchanged
// between the VRAM arbiter, its posted-write FIFO and the CPU bus interface.
package vram_pkg;

    localparam int unsigned VRAM_AW   = 10;   // 1024 character cells
    localparam int unsigned VRAM_DW   = 8;    // one character code per cell
    localparam int unsigned TEXT_COLS = 60;
    localparam int unsigned TEXT_ROWS = 17;   // 60x17 = 1020 cells used

    // One posted CPU write waiting for a free VRAM cycle.
    typedef struct packed {
        logic [VRAM_AW-1:0] adr;
        logic [VRAM_DW-1:0] data;
    } wreq_t;

    // CPU read sequencer.
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,   // ready for a new CPU access
        R_DRAIN = 2'd1,   // read latched, waiting for FIFO empty and no LCD fetch
        R_DATA  = 2'd2    // read issued last cycle, data on ram_dout now
    } rd_state_t;

    // Which requester issued the read whose data returns next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LCD  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU-side access bus of the VRAM arbiter.
//
// Handshake: the CPU raises cpu_req with cpu_we/cpu_adr/cpu_wdata stable and
// holds all of them until it samples cpu_ready high on a rising PixelClk edge;
// that edge is the single transfer point (cpu_req & cpu_ready). The arbiter
// may hold cpu_ready low for any number of cycles. Read data comes back later
// as a one-cycle cpu_rvalid pulse; cpu_rdata keeps its value until the next
// pulse. Only one read is ever outstanding.
interface vram_arbiter_if;
    import vram_pkg::*;

    logic               cpu_req;
    logic               cpu_we;
    logic [VRAM_AW-1:0] cpu_adr;
    logic [VRAM_DW-1:0] cpu_wdata;
    logic               cpu_ready;
    logic               cpu_rvalid;
    logic [VRAM_DW-1:0] cpu_rdata;

    // CPU side drives the request, arbiter side answers it.
    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata
    );

endinterface

// File: rtl/vram_wfifo.sv
// vram_wfifo: synchronous FIFO of posted VRAM writes. Pointers carry one
// extra MSB so full and empty are told apart without a separate counter;
// both flags come straight from the registered pointers. DEPTH must be a
// power of two so the pointers wrap by natural overflow.
module vram_wfifo
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  PixelClk,
    input  logic  nRST,
    input  logic  push_i,
    input  wreq_t push_data_i,
    input  logic  pop_i,
    output logic  full_o,
    output logic  empty_o,
    output wreq_t head_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    wreq_t       mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    // Guard against pushing into a full FIFO or popping an empty one.
    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_ok};
    end

    // Pointer registers; reset discards every pending entry.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers say which slots are live.
    always_ff @(posedge PixelClk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port text VRAM between the LCD character
// fetcher (hard real-time, always wins its cycle) and the CPU (posted writes
// through a small FIFO, reads issued once that FIFO has drained).
//
// Optional feature macro: VRAM_CLEAR_EN. When defined, a sweep fills every
// VRAM cell with CLEAR_CHAR after reset; clear_busy_o is held high through
// reset and the sweep so the CPU stays locked out until the screen is blank.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned   AW          = VRAM_AW,
    parameter int unsigned   DW          = VRAM_DW,
    parameter int unsigned   WFIFO_DEPTH = 4,
    parameter logic [DW-1:0] CLEAR_CHAR  = 8'h20
) (
    input  logic            PixelClk,
    input  logic            nRST,
    // LCD character fetcher
    input  logic            lcd_req_i,
    input  logic [AW-1:0]   lcd_adr_i,
    output logic [DW-1:0]   lcd_dout_o,
    // CPU bus
    vram_arbiter_if.slave   cpu,
    // BSRAM port
    output logic            ram_ce_o,
    output logic            ram_wre_o,
    output logic [AW-1:0]   ram_ad_o,
    output logic [DW-1:0]   ram_din_o,
    input  logic [DW-1:0]   ram_dout_i,
    // Status / debug
    output logic            clear_busy_o,
    output rd_state_t       rd_state_o
);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    wreq_t          fifo_push_data;
    wreq_t          fifo_head;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;

    logic           cpu_ready;
    logic           wr_accept;
    logic           rd_accept;
    logic           rd_issue;

    rd_state_t      rd_state_q, rd_state_d;
    logic [AW-1:0]  rd_adr_q, rd_adr_d;
    owner_t         owner_q, owner_d;
    logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;

    logic           ram_ce_d;
    logic           ram_wre_d;
    logic [AW-1:0]  ram_ad_q, ram_ad_d;
    logic [DW-1:0]  ram_din_d;

    logic           clr_busy;
    logic [AW-1:0]  clr_adr;

    // ------------------------------------------------------------------
    // Optional post-reset clear sweep
    // ------------------------------------------------------------------
`ifdef VRAM_CLEAR_EN
    logic           clr_busy_q, clr_busy_d;
    logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
    logic           clr_wr;

    // The sweep writes whenever the LCD does not own the cycle; it ends
    // after the write to the last address.
    always_comb begin
        clr_wr     = clr_busy_q && !lcd_req_i;
        clr_cnt_d  = clr_cnt_q + {{(AW-1){1'b0}}, clr_wr};
        clr_busy_d = clr_busy_q && !(clr_wr && (&clr_cnt_q));
    end

    // Sweep state restarts from address 0 on every reset.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            clr_busy_q <= 1'b1;
            clr_cnt_q  <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_adr  = clr_cnt_q;
`else
    assign clr_busy = 1'b0;
    assign clr_adr  = '0;
`endif

    // ------------------------------------------------------------------
    // Posted-write FIFO
    // ------------------------------------------------------------------
    // Ready comes only from registered state, so a write offered while the
    // FIFO is full is refused even if an entry leaves in that same cycle.
    always_comb begin
        cpu_ready      = !fifo_full && (rd_state_q == R_IDLE) && !clr_busy;
        wr_accept      = cpu.cpu_req && cpu.cpu_we && cpu_ready;
        rd_accept      = cpu.cpu_req && !cpu.cpu_we && cpu_ready;
        fifo_push      = wr_accept;
        fifo_push_data = '{adr: cpu.cpu_adr, data: cpu.cpu_wdata};
    end

    vram_wfifo #(
        .DEPTH       (WFIFO_DEPTH)
    ) u_wfifo (
        .PixelClk    (PixelClk),
        .nRST        (nRST),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // ------------------------------------------------------------------
    // Per-cycle VRAM port grant: LCD, clear sweep, CPU read, FIFO write
    // ------------------------------------------------------------------
    always_comb begin
        ram_ce_d  = 1'b0;
        ram_wre_d = 1'b0;
        ram_ad_d  = ram_ad_q;         // address parks on its last value
        ram_din_d = fifo_head.data;
        owner_d   = OWN_NONE;
        fifo_pop  = 1'b0;
        rd_issue  = 1'b0;
        if (lcd_req_i) begin
            ram_ce_d = 1'b1;
            ram_ad_d = lcd_adr_i;
            owner_d  = OWN_LCD;
        end else if (clr_busy) begin
            ram_ce_d  = 1'b1;
            ram_wre_d = 1'b1;
            ram_ad_d  = clr_adr;
            ram_din_d = CLEAR_CHAR;
        end else if ((rd_state_q == R_DRAIN) && fifo_empty) begin
            // Every earlier write has committed, so the read sees it.
            ram_ce_d = 1'b1;
            ram_ad_d = rd_adr_q;
            owner_d  = OWN_CPU;
            rd_issue = 1'b1;
        end else if (!fifo_empty) begin
            ram_ce_d  = 1'b1;
            ram_wre_d = 1'b1;
            ram_ad_d  = fifo_head.adr;
            ram_din_d = fifo_head.data;
            fifo_pop  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // CPU read sequencer
    // ------------------------------------------------------------------
    // Next-state for the read FSM; the address is latched on acceptance so
    // the CPU may change its bus afterwards.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_adr_d   = rd_adr_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_state_d = R_DRAIN;
                    rd_adr_d   = cpu.cpu_adr;
                end
            end
            R_DRAIN: begin
                if (rd_issue) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rd_state_d = R_IDLE;
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    // Returning read data is taken only when the CPU issued that read, so an
    // LCD fetch never disturbs the CPU's data.
    always_comb begin
        cpu_rdata_d = (owner_q == OWN_CPU) ? ram_dout_i : cpu_rdata_q;
    end

    // State, ownership tag, held read data and parked BSRAM address.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            rd_state_q  <= R_IDLE;
            rd_adr_q    <= '0;
            owner_q     <= OWN_NONE;
            cpu_rdata_q <= '0;
            ram_ad_q    <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_adr_q    <= rd_adr_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            ram_ad_q    <= ram_ad_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The LCD sees the BSRAM exactly as if it were wired to it directly.
    assign lcd_dout_o     = ram_dout_i;

    assign ram_ce_o       = ram_ce_d;
    assign ram_wre_o      = ram_wre_d;
    assign ram_ad_o       = ram_ad_d;
    assign ram_din_o      = ram_din_d;

    assign cpu.cpu_ready  = cpu_ready;
    assign cpu.cpu_rvalid = (rd_state_q == R_DATA);
    assign cpu.cpu_rdata  = cpu_rdata_d;

    assign clear_busy_o   = clr_busy;
    assign rd_state_o     = rd_state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: bench for vram_arbiter with a behavioural BSRAM, an
// in-order write scoreboard, a flat memory model for CPU read data and LCD
// timing checks. Build with +define+VRAM_CLEAR_EN to exercise the clear sweep.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef VRAM_CLEAR_EN
    localparam bit CLR_EN    = 1'b1;
    localparam int CLR_START = 0;
`else
    localparam bit CLR_EN    = 1'b0;
    localparam int CLR_START = 1024;
`endif

    // ---------------- clock / reset ----------------
    logic PixelClk = 1'b0;
    logic nRST     = 1'b0;
    always #5 PixelClk = ~PixelClk;

    // ---------------- DUT ----------------
    logic          lcd_req_i = 1'b0;
    logic [AW-1:0] lcd_adr_i = '0;
    logic [DW-1:0] lcd_dout_o;
    logic          ram_ce_o, ram_wre_o;
    logic [AW-1:0] ram_ad_o;
    logic [DW-1:0] ram_din_o;
    logic [DW-1:0] ram_dout_i = '0;
    logic          clear_busy_o;
    rd_state_t     rd_state_o;

    vram_arbiter_if cpu_bus ();

    vram_arbiter u_dut (
        .PixelClk     (PixelClk),
        .nRST         (nRST),
        .lcd_req_i    (lcd_req_i),
        .lcd_adr_i    (lcd_adr_i),
        .lcd_dout_o   (lcd_dout_o),
        .cpu          (cpu_bus),
        .ram_ce_o     (ram_ce_o),
        .ram_wre_o    (ram_wre_o),
        .ram_ad_o     (ram_ad_o),
        .ram_din_o    (ram_din_o),
        .ram_dout_i   (ram_dout_i),
        .clear_busy_o (clear_busy_o),
        .rd_state_o   (rd_state_o)
    );

    // ---------------- behavioural BSRAM ----------------
    logic [DW-1:0] bsram [1024];
    bit            bsram_init = 1'b0;
    always @(posedge PixelClk) begin
        if (!bsram_init) begin
            for (int i = 0; i < 1024; i++) bsram[i] <= 8'(i * 37 + 11);
            bsram_init <= 1'b1;
        end else if (ram_ce_o) begin
            if (ram_wre_o) bsram[ram_ad_o] <= ram_din_o;
            else           ram_dout_i      <= bsram[ram_ad_o];
        end
    end

    // ---------------- checker ----------------
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [17:0]   exp_q [$];         // accepted writes not yet seen on the BSRAM port
    logic [DW-1:0] ref_mem [1024];    // VRAM contents as the CPU should see them
    bit            rd_pending = 1'b0;
    logic [DW-1:0] rd_exp;
    int            rd_wait = 0;
    int            last_rd_lat = 0;
    bit            lcd_pend = 1'b0;
    logic [DW-1:0] lcd_exp;
    bit            mon_en = 1'b0;
    int            clr_seen = CLR_START;

    always @(negedge PixelClk) begin
        bit exp_ready;
        if (nRST && mon_en) begin
            // ready follows from what is outstanding before this cycle's events
            exp_ready = (exp_q.size() < DEPTH) && !rd_pending && (clr_seen >= 1024);
            chk("cpu_ready", 32'(cpu_bus.cpu_ready), 32'(exp_ready));
            chk("clear_busy", 32'(clear_busy_o), 32'(clr_seen < 1024));
            if (lcd_pend) chk("lcd_dout", 32'(lcd_dout_o), 32'(lcd_exp));
            lcd_pend = 1'b0;
            if (lcd_req_i) begin
                chk("lcd_ce", 32'(ram_ce_o), 32'd1);
                chk("lcd_wre", 32'(ram_wre_o), 32'd0);
                chk("lcd_ad", 32'(ram_ad_o), 32'(lcd_adr_i));
                lcd_pend = 1'b1;
                lcd_exp  = bsram[lcd_adr_i];
            end else if (ram_ce_o && ram_wre_o) begin
                if (clr_seen < 1024) begin
                    chk("clr_wr", 32'({ram_ad_o, ram_din_o}), 32'({10'(clr_seen), 8'h20}));
                    clr_seen++;
                end else if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'({ram_ad_o, ram_din_o}), 32'h3ffff);
                end else begin
                    chk("wr_commit", 32'({ram_ad_o, ram_din_o}), 32'(exp_q.pop_front()));
                end
            end
            if (cpu_bus.cpu_rvalid) begin
                chk("rvalid_expected", 32'(rd_pending), 32'd1);
                chk("rdata", 32'(cpu_bus.cpu_rdata), 32'(rd_exp));
                last_rd_lat = rd_wait + 1;
                rd_pending  = 1'b0;
            end else if (rd_pending) begin
                rd_wait++;
                if (rd_wait > 60) begin
                    chk("rd_timeout", 32'(rd_pending), 32'd0);
                    rd_pending = 1'b0;
                end
            end
            if (cpu_bus.cpu_req && cpu_bus.cpu_ready) begin
                if (cpu_bus.cpu_we) begin
                    exp_q.push_back({cpu_bus.cpu_adr, cpu_bus.cpu_wdata});
                    ref_mem[cpu_bus.cpu_adr] = cpu_bus.cpu_wdata;
                end else begin
                    rd_pending = 1'b1;
                    rd_exp     = ref_mem[cpu_bus.cpu_adr];
                    rd_wait    = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic cpu_access(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] data);
        bit acc = 1'b0;
        int n = 0;
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_adr   = adr;
        cpu_bus.cpu_wdata = data;
        while (!acc && n < 3000) begin
            @(negedge PixelClk);
            acc = cpu_bus.cpu_ready;
            n++;
            if (!acc) begin @(posedge PixelClk); #1; end
        end
        if (acc) begin @(posedge PixelClk); #1; end
        cpu_bus.cpu_req = 1'b0;
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic lcd_pulse(input logic [AW-1:0] adr);
        lcd_req_i = 1'b1;
        lcd_adr_i = adr;
        @(posedge PixelClk); #1;
        lcd_req_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 200 && (exp_q.size() != 0 || rd_pending)) begin
            @(negedge PixelClk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge PixelClk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit stop;
        int nbad;
        for (int i = 0; i < 1024; i++) ref_mem[i] = CLR_EN ? 8'h20 : 8'(i * 37 + 11);
        cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_adr = '0;   cpu_bus.cpu_wdata = '0;

        // reset values, sampled while reset is held
        repeat (3) @(posedge PixelClk);
        @(negedge PixelClk);
        chk("rst_rvalid", 32'(cpu_bus.cpu_rvalid), 32'd0);
        chk("rst_rdata", 32'(cpu_bus.cpu_rdata), 32'd0);
        chk("rst_state", 32'(rd_state_o), 32'(R_IDLE));
        chk("rst_ready", 32'(cpu_bus.cpu_ready), 32'(!CLR_EN));
        chk("rst_busy", 32'(clear_busy_o), 32'(CLR_EN));
        chk("rst_ce", 32'(ram_ce_o), 32'd0);
        @(posedge PixelClk); #1;
        nRST   = 1'b1;
        mon_en = 1'b1;

`ifdef VRAM_CLEAR_EN
        begin
            int busy_cycles = 0, lcd_during = 0, n = 0;
            while (clear_busy_o && n < 3000) begin
                lcd_req_i = (n % 8 == 7);
                lcd_adr_i = 10'(n);
                @(negedge PixelClk);
                if (lcd_req_i) lcd_during++;
                busy_cycles++;
                @(posedge PixelClk); #1;
                n++;
            end
            lcd_req_i = 1'b0;
            chk("clr_cycles", 32'(busy_cycles), 32'(1024 + lcd_during));
            chk("clr_count", 32'(clr_seen), 32'd1024);
        end
`endif

        // LCD fetch of a known cell
        cpu_access(1'b1, 10'd5, 8'h41);
        repeat (2) @(posedge PixelClk); #1;
        lcd_pulse(10'd5);
        @(negedge PixelClk);
        chk("lcd_41", 32'(lcd_dout_o), 32'h41);
        @(posedge PixelClk); #1;

        // single write commits the cycle after acceptance
        cpu_access(1'b1, 10'd0, 8'h48);
        @(negedge PixelClk);
        chk("wr_latency", 32'({ram_ce_o, ram_wre_o, ram_ad_o, ram_din_o}), 32'({2'b11, 10'd0, 8'h48}));
        @(posedge PixelClk); #1;

        // five writes against six cycles of LCD ownership
        fork
            begin
                lcd_req_i = 1'b1; lcd_adr_i = 10'd700;
                repeat (6) @(posedge PixelClk);
                #1 lcd_req_i = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) cpu_access(1'b1, 10'(10 + i), 8'(8'h60 + i));
            end
        join
        wait_idle();

        // read-after-write ordering
        cpu_access(1'b1, 10'd100, 8'h7E);
        cpu_access(1'b0, 10'd100, 8'h00);
        wait_idle();
        chk("raw_rdata", 32'(cpu_bus.cpu_rdata), 32'h7E);

        // uncontended read latency
        cpu_access(1'b0, 10'd5, 8'h00);
        wait_idle();
        chk("rd_latency", 32'(last_rd_lat), 32'd2);

        // LCD fetch in the cycle the CPU's read data returns
        cpu_access(1'b0, 10'd100, 8'h00);
        @(posedge PixelClk); #1;
        lcd_pulse(10'd5);
        @(negedge PixelClk);
        chk("rdata_hold", 32'(cpu_bus.cpu_rdata), 32'h7E);
        chk("lcd_after_cpu", 32'(lcd_dout_o), 32'h41);
        @(posedge PixelClk); #1;
        wait_idle();

        // randomized traffic with sparse random LCD fetches
        stop = 1'b0;
        fork
            begin
                while (!stop) begin
                    lcd_req_i = ($urandom_range(0, 5) == 0);
                    lcd_adr_i = 10'($urandom_range(0, 1023));
                    @(posedge PixelClk); #1;
                end
                lcd_req_i = 1'b0;
            end
            begin
                for (int i = 0; i < 250; i++) begin
                    logic [AW-1:0] a;
                    a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7))
                                                    : 10'($urandom_range(0, 1023));
                    cpu_access(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 2)) begin @(posedge PixelClk); #1; end
                end
                stop = 1'b1;
            end
        join
        wait_idle();

`ifndef VRAM_CLEAR_EN
        // reset while a read is in flight: it is dropped with no rvalid
        cpu_access(1'b0, 10'd3, 8'h00);
        nRST       = 1'b0;
        rd_pending = 1'b0;
        lcd_pend   = 1'b0;
        repeat (2) @(posedge PixelClk);
        @(negedge PixelClk);
        chk("mid_rst_rvalid", 32'(cpu_bus.cpu_rvalid), 32'd0);
        chk("mid_rst_state", 32'(rd_state_o), 32'(R_IDLE));
        chk("mid_rst_rdata", 32'(cpu_bus.cpu_rdata), 32'd0);
        @(posedge PixelClk); #1;
        nRST = 1'b1;
        repeat (6) @(posedge PixelClk); #1;
`endif

        // final VRAM image against the model
        nbad = 0;
        for (int i = 0; i < 1024; i++) if (bsram[i] !== ref_mem[i]) nbad++;
        chk("mem_final", 32'(nbad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
